// File: rtl/proc_sim_pkg.sv
// Shared types and helpers for the processor run-and-check harness.
package proc_sim_pkg;

    typedef enum logic [2:0] {IDLE, INIT, HOLD, RUN, CHECK, DONE} state_t;

    localparam logic [31:0] DEFAULT_INIT_VALUE = 32'hcafebabe;

    // Address width for a table of the given depth; never narrower than one bit.
    function automatic int unsigned addr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/exp_image_ram.sv
// Expected register image: {care, value} per GPR, synchronous write, combinational read.
module exp_image_ram
    import proc_sim_pkg::*;
#(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned WIDTH = 33
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [addr_w(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [addr_w(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/proc_run_checker.sv
// Run-and-check controller: pre-loads the GPRs, holds the core in reset, runs it for a
// programmed budget, then scans the register file against a masked expected image.
module proc_run_checker
    import proc_sim_pkg::*;
#(
    parameter int unsigned NUM_REGS     = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned CYCLE_W      = 16,
    parameter int unsigned RESET_CYCLES = 2,
    parameter logic [31:0] INIT_VALUE   = DEFAULT_INIT_VALUE,
    parameter bit          STOP_ON_FAIL = 1'b1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [CYCLE_W-1:0]            cycle_budget,
    input  logic                          exp_we,
    input  logic [$clog2(NUM_REGS)-1:0]   exp_addr,
    input  logic [DATA_W-1:0]             exp_data,
    input  logic                          exp_care,
    output logic                          cpu_reset,
    output logic                          rf_we,
    output logic [$clog2(NUM_REGS)-1:0]   rf_waddr,
    output logic [DATA_W-1:0]             rf_wdata,
    output logic [$clog2(NUM_REGS)-1:0]   rf_raddr,
    input  logic [DATA_W-1:0]             rf_rdata,
    output logic                          busy,
    output logic                          done,
    output logic                          pass,
    output logic [$clog2(NUM_REGS+1)-1:0] fail_count,
    output logic [$clog2(NUM_REGS)-1:0]   fail_index,
    output logic [DATA_W-1:0]             fail_actual,
    output logic [DATA_W-1:0]             fail_expected
);

    localparam int unsigned AW = $clog2(NUM_REGS);
    localparam int unsigned FW = $clog2(NUM_REGS + 1);
    localparam int unsigned RW = addr_w(RESET_CYCLES + 1);
    localparam int unsigned CW = (CYCLE_W > RW) ? CYCLE_W : RW;
    localparam logic [AW-1:0] LAST = AW'(NUM_REGS - 1);

    state_t             state;
    logic [AW-1:0]      idx;
    logic [CW-1:0]      cnt;
    logic [CYCLE_W-1:0] budget;
    logic [DATA_W:0]    exp_word;
    logic               idle_like;
    logic               img_we;
    logic               mismatch;

    assign idle_like = (state == IDLE) || (state == DONE);
    assign img_we    = exp_we && idle_like && (exp_addr != '0);
    assign mismatch  = (state == CHECK) && exp_word[DATA_W] &&
                       (rf_rdata != exp_word[DATA_W-1:0]);

    exp_image_ram #(
        .DEPTH (NUM_REGS),
        .WIDTH (DATA_W + 1)
    ) u_image (
        .clk   (clk),
        .we    (img_we),
        .waddr (exp_addr),
        .wdata ({exp_care, exp_data}),
        .raddr (idx),
        .rdata (exp_word)
    );

    assign rf_waddr = idx;
    assign rf_raddr = (state == CHECK) ? idx : '0;
    assign rf_wdata = DATA_W'(INIT_VALUE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            idx           <= '0;
            cnt           <= '0;
            budget        <= '0;
            cpu_reset     <= 1'b1;
            rf_we         <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            fail_count    <= '0;
            fail_index    <= '0;
            fail_actual   <= '0;
            fail_expected <= '0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state         <= INIT;
                        idx           <= AW'(1);
                        budget        <= cycle_budget;
                        rf_we         <= 1'b1;
                        busy          <= 1'b1;
                        done          <= 1'b0;
                        pass          <= 1'b0;
                        fail_count    <= '0;
                        fail_index    <= '0;
                        fail_actual   <= '0;
                        fail_expected <= '0;
                    end
                end
                INIT: begin
                    if (idx == LAST) begin
                        state <= HOLD;
                        rf_we <= 1'b0;
                        idx   <= AW'(1);
                        cnt   <= CW'(RESET_CYCLES - 1);
                    end else begin
                        idx <= idx + AW'(1);
                    end
                end
                HOLD: begin
                    if (cnt == '0) begin
                        // A zero budget never releases the core.
                        if (budget == '0) begin
                            state <= CHECK;
                        end else begin
                            state     <= RUN;
                            cpu_reset <= 1'b0;
                            cnt       <= CW'(budget) - CW'(1);
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                RUN: begin
                    if (cnt == '0) begin
                        state     <= CHECK;
                        cpu_reset <= 1'b1;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                CHECK: begin
                    if (mismatch) begin
                        fail_count <= fail_count + FW'(1);
                        if (fail_count == '0) begin
                            fail_index    <= idx;
                            fail_actual   <= rf_rdata;
                            fail_expected <= exp_word[DATA_W-1:0];
                        end
                    end
                    if ((mismatch && STOP_ON_FAIL) || (idx == LAST)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (fail_count == '0) && !mismatch;
                    end else begin
                        idx <= idx + AW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_proc_run_checker.sv
// Bench for proc_run_checker: a stop-on-fail and a full-scan instance share stimulus, each
// with its own GPR array and a toy core that writes fixed registers while out of reset.
module tb_proc_run_checker;

    localparam logic [31:0] MARK = 32'hcafebabe;

    typedef struct packed {
        logic [7:0]  lat;
        logic        pass;
        logic [5:0]  cnt;
        logic [4:0]  idx;
        logic [31:0] act;
        logic [31:0] expv;
        logic [5:0]  nwe;
        logic [7:0]  nrun;
        logic [5:0]  nreads;
        logic [4:0]  maxrd;
    } exp_t;

    typedef struct {
        int          budget;
        int          wr_r0;
        logic [31:0] wr_v0;
        int          wr_r1;
        logic [31:0] wr_v1;
        int          img_r0;
        logic [31:0] img_v0;
        int          img_r1;
        logic [31:0] img_v1;
        int          dc_r;
        exp_t        e_stop;
        exp_t        e_full;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] cycle_budget;
    logic        exp_we;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
    logic        exp_care;

    logic        cpu_reset [2];
    logic        rf_we [2];
    logic [4:0]  rf_waddr [2];
    logic [31:0] rf_wdata [2];
    logic [4:0]  rf_raddr [2];
    logic [31:0] rf_rdata [2];
    logic        busy [2];
    logic        done [2];
    logic        pass [2];
    logic [5:0]  fail_count [2];
    logic [4:0]  fail_index [2];
    logic [31:0] fail_actual [2];
    logic [31:0] fail_expected [2];

    logic [31:0] gpr [2][32];
    int          prog_r [2];
    logic [31:0] prog_v [2];

    int   lat_cnt [2];
    int   nwe [2];
    int   nrun [2];
    int   nreads [2];
    int   maxrd [2];
    logic done_prev [2];
    int   ndone = 0;
    exp_t sbq0 [$];
    exp_t sbq1 [$];
    int   n_vec = 0;
    int   n_miss = 0;
    vec_t vecs [6];
    vec_t clean;

    always #5 clk = ~clk;

    proc_run_checker #(.STOP_ON_FAIL(1'b1)) dut_stop (
        .clk (clk), .reset (reset), .start (start), .cycle_budget (cycle_budget),
        .exp_we (exp_we), .exp_addr (exp_addr), .exp_data (exp_data), .exp_care (exp_care),
        .cpu_reset (cpu_reset[0]), .rf_we (rf_we[0]), .rf_waddr (rf_waddr[0]),
        .rf_wdata (rf_wdata[0]), .rf_raddr (rf_raddr[0]), .rf_rdata (rf_rdata[0]),
        .busy (busy[0]), .done (done[0]), .pass (pass[0]), .fail_count (fail_count[0]),
        .fail_index (fail_index[0]), .fail_actual (fail_actual[0]),
        .fail_expected (fail_expected[0])
    );

    proc_run_checker #(.STOP_ON_FAIL(1'b0)) dut_full (
        .clk (clk), .reset (reset), .start (start), .cycle_budget (cycle_budget),
        .exp_we (exp_we), .exp_addr (exp_addr), .exp_data (exp_data), .exp_care (exp_care),
        .cpu_reset (cpu_reset[1]), .rf_we (rf_we[1]), .rf_waddr (rf_waddr[1]),
        .rf_wdata (rf_wdata[1]), .rf_raddr (rf_raddr[1]), .rf_rdata (rf_rdata[1]),
        .busy (busy[1]), .done (done[1]), .pass (pass[1]), .fail_count (fail_count[1]),
        .fail_index (fail_index[1]), .fail_actual (fail_actual[1]),
        .fail_expected (fail_expected[1])
    );

    // GPR models: pre-load writes from the checker, program writes from the toy core.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rf_we[k] === 1'b1) gpr[k][rf_waddr[k]] <= rf_wdata[k];
            if (cpu_reset[k] === 1'b0) begin
                for (int i = 0; i < 2; i++) begin
                    if (prog_r[i] != 0) gpr[k][prog_r[i]] <= prog_v[i];
                end
            end
        end
    end

    assign rf_rdata[0] = gpr[0][rf_raddr[0]];
    assign rf_rdata[1] = gpr[1][rf_raddr[1]];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input int lat, input bit ps, input int cnt, input int idx,
                                input logic [31:0] act, input logic [31:0] expv,
                                input int rn, input int rd);
        exp_t e;
        e.lat    = 8'(lat);
        e.pass   = ps;
        e.cnt    = 6'(cnt);
        e.idx    = 5'(idx);
        e.act    = act;
        e.expv   = expv;
        e.nwe    = 6'd31;
        e.nrun   = 8'(rn);
        e.nreads = 6'(rd);
        e.maxrd  = 5'(rd);
        return e;
    endfunction

    task automatic mon(input int k);
        exp_t  e;
        string tag;
        tag = (k == 0) ? "stop" : "full";
        if (rf_we[k] === 1'b1) begin
            chk({tag, ".preload_data"}, 64'(rf_wdata[k]), 64'(MARK));
            chk({tag, ".preload_addr"}, 64'(rf_waddr[k]), 64'(nwe[k] + 1));
            nwe[k]++;
        end
        if (cpu_reset[k] === 1'b0) nrun[k]++;
        if (rf_raddr[k] != 5'd0) begin
            nreads[k]++;
            if (int'(rf_raddr[k]) > maxrd[k]) maxrd[k] = int'(rf_raddr[k]);
        end
        if (done[k] === 1'b1 && done_prev[k] !== 1'b1) begin
            if ((k == 0 && sbq0.size() == 0) || (k == 1 && sbq1.size() == 0)) begin
                chk({tag, ".unexpected_done"}, 64'(done[k]), 64'd0);
            end else begin
                if (k == 0) e = sbq0.pop_front();
                else e = sbq1.pop_front();
                chk({tag, ".latency"}, 64'(lat_cnt[k]), 64'(e.lat));
                chk({tag, ".pass"}, 64'(pass[k]), 64'(e.pass));
                chk({tag, ".busy"}, 64'(busy[k]), 64'd0);
                chk({tag, ".fail_count"}, 64'(fail_count[k]), 64'(e.cnt));
                chk({tag, ".fail_index"}, 64'(fail_index[k]), 64'(e.idx));
                chk({tag, ".fail_actual"}, 64'(fail_actual[k]), 64'(e.act));
                chk({tag, ".fail_expected"}, 64'(fail_expected[k]), 64'(e.expv));
                chk({tag, ".rf_we_pulses"}, 64'(nwe[k]), 64'(e.nwe));
                chk({tag, ".run_cycles"}, 64'(nrun[k]), 64'(e.nrun));
                chk({tag, ".scan_reads"}, 64'(nreads[k]), 64'(e.nreads));
                chk({tag, ".scan_max_addr"}, 64'(maxrd[k]), 64'(e.maxrd));
            end
            ndone++;
        end
        done_prev[k] = done[k];
        lat_cnt[k]++;
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_image(input vec_t v);
        for (int r = 1; r < 32; r++) begin
            exp_we   = 1'b1;
            exp_addr = 5'(r);
            exp_care = (r != v.dc_r);
            exp_data = (r == v.img_r0) ? v.img_v0 :
                       (r == v.img_r1) ? v.img_v1 :
                       (r == v.dc_r)   ? 32'h0 : MARK;
            step();
        end
        exp_we = 1'b0;
    endtask

    task automatic start_run(input vec_t v, input bit expect_done);
        prog_r[0]    = v.wr_r0;
        prog_v[0]    = v.wr_v0;
        prog_r[1]    = v.wr_r1;
        prog_v[1]    = v.wr_v1;
        cycle_budget = 16'(v.budget);
        if (expect_done) begin
            sbq0.push_back(v.e_stop);
            sbq1.push_back(v.e_full);
        end
        for (int k = 0; k < 2; k++) begin
            lat_cnt[k] = 0;
            nwe[k]     = 0;
            nrun[k]    = 0;
            nreads[k]  = 0;
            maxrd[k]   = 0;
        end
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int target);
        for (int c = 0; c < 300 && ndone < target; c++) step();
        chk({name, ".completed"}, 64'(ndone), 64'(target));
        step();
    endtask

    task automatic chk_reset_state(input string name);
        for (int k = 0; k < 2; k++) begin
            chk({name, ".cpu_reset"}, 64'(cpu_reset[k]), 64'd1);
            chk({name, ".rf_we"}, 64'(rf_we[k]), 64'd0);
            chk({name, ".busy"}, 64'(busy[k]), 64'd0);
            chk({name, ".done"}, 64'(done[k]), 64'd0);
            chk({name, ".pass"}, 64'(pass[k]), 64'd0);
            chk({name, ".fail_count"}, 64'(fail_count[k]), 64'd0);
            chk({name, ".fail_index"}, 64'(fail_index[k]), 64'd0);
            chk({name, ".fail_actual"}, 64'(fail_actual[k]), 64'd0);
            chk({name, ".fail_expected"}, 64'(fail_expected[k]), 64'd0);
        end
    endtask

    initial begin
        int target;
        reset = 1'b0;
        start = 1'b0;
        exp_we = 1'b0;
        exp_addr = '0;
        exp_data = '0;
        exp_care = 1'b0;
        cycle_budget = '0;
        prog_r[0] = 0;
        prog_r[1] = 0;
        prog_v[0] = '0;
        prog_v[1] = '0;

        //            budget wr_r0 wr_v0 wr_r1 wr_v1 img_r0 img_v0 img_r1 img_v1 dc  stop / full
        vecs[0] = '{5, 2, 32'h10, 29, 32'h7ffc, 2, 32'h10, 29, 32'h7ffc, 0,
                    mk(70, 1, 0, 0, 0, 0, 5, 31), mk(70, 1, 0, 0, 0, 0, 5, 31)};
        vecs[1] = '{5, 5, 32'h7, 0, 32'h0, 5, 32'h8, 0, 32'h0, 0,
                    mk(44, 0, 1, 5, 32'h7, 32'h8, 5, 5), mk(70, 0, 1, 5, 32'h7, 32'h8, 5, 31)};
        vecs[2] = '{3, 3, 32'h33, 9, 32'h99, 3, 32'h3, 9, 32'h9, 0,
                    mk(40, 0, 1, 3, 32'h33, 32'h3, 3, 3), mk(68, 0, 2, 3, 32'h33, 32'h3, 3, 31)};
        vecs[3] = '{7, 9, 32'hdeadbeef, 0, 32'h0, 0, 32'h0, 0, 32'h0, 9,
                    mk(72, 1, 0, 0, 0, 0, 7, 31), mk(72, 1, 0, 0, 0, 0, 7, 31)};
        vecs[4] = '{0, 4, 32'h1234, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0,
                    mk(65, 1, 0, 0, 0, 0, 0, 31), mk(65, 1, 0, 0, 0, 0, 0, 31)};
        vecs[5] = '{1, 31, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0,
                    mk(66, 0, 1, 31, 32'h0, MARK, 1, 31), mk(66, 0, 1, 31, 32'h0, MARK, 1, 31)};
        clean   = '{5, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0,
                    mk(70, 1, 0, 0, 0, 0, 5, 31), mk(70, 1, 0, 0, 0, 0, 5, 31)};

        repeat (3) step();
        chk_reset_state("reset");
        reset = 1'b1;
        step();

        for (int i = 0; i < 6; i++) begin
            target = ndone + 2;
            load_image(vecs[i]);
            start_run(vecs[i], 1'b1);
            wait_done($sformatf("vec%0d", i), target);
        end

        // Abort a run with reset while the core is running.
        load_image(clean);
        clean.budget = 20;
        start_run(clean, 1'b0);
        for (int c = 0; c < 100 && cpu_reset[0] !== 1'b0; c++) step();
        chk("abort.reached_run", 64'(cpu_reset[0]), 64'd0);
        repeat (3) step();
        reset = 1'b0;
        step();
        chk_reset_state("abort");
        reset = 1'b1;
        step();

        // Fresh run; start and image writes while busy must be ignored.
        clean.budget = 5;
        target = ndone + 2;
        start_run(clean, 1'b1);
        for (int p = 0; p < 2; p++) begin
            repeat ((p == 0) ? 10 : 30) step();
            start    = 1'b1;
            exp_we   = 1'b1;
            exp_addr = 5'd10;
            exp_data = 32'h0;
            exp_care = 1'b1;
            step();
            start  = 1'b0;
            exp_we = 1'b0;
        end
        wait_done("busy_ignore", target);

        chk("scoreboard.drained", 64'(sbq0.size() + sbq1.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/proc_run_checker.md
Name: proc_run_checker

Overview:
- Synthesizable, parametrised run-and-check controller for the single-cycle MIPS core and its successors.
- Phases, in order:
  - pre-loads the GPR file with a marker value;
  - holds the core in reset;
  - lets the core run for a programmable cycle budget;
  - scans the register file against an internally stored expected image with per-register don't-care masking.
- Reports pass/fail, mismatch count and first-failure details.
- Used in FPGA bring-up and in regression benches in place of hand-written check loops.

Parameters:
- NUM_REGS, 32, number of GPRs; register 0 is never written or checked.
- DATA_W, 32, register width.
- CYCLE_W, 16, width of the cycle-budget counter.
- RESET_CYCLES, 2, cycles the core is held in reset after the pre-load phase; must be >= 1.
- INIT_VALUE, 32'hcafebabe, marker written to registers 1..NUM_REGS-1 (truncated or zero-extended to DATA_W).
- STOP_ON_FAIL, 1, 1 = stop the scan at the first mismatch; 0 = scan all registers and count mismatches.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse; accepted only in IDLE or DONE.
- cycle_budget  in  CYCLE_W  core run length, sampled when start is accepted.
- exp_we  in  1  expected-image write strobe; honoured only in IDLE or DONE.
- exp_addr  in  $clog2(NUM_REGS)  expected-image index.
- exp_data  in  DATA_W  expected value.
- exp_care  in  1  0 = register is don't-care.
- cpu_reset  out  1  reset to the core, active-high.
- rf_we  out  1  GPR write enable (pre-load phase).
- rf_waddr  out  $clog2(NUM_REGS)  GPR write address.
- rf_wdata  out  DATA_W  GPR write data.
- rf_raddr  out  $clog2(NUM_REGS)  GPR read address.
- rf_rdata  in  DATA_W  GPR read data; combinational, same cycle as rf_raddr.
- busy  out  1  high in INIT, HOLD, RUN, CHECK.
- done  out  1  high in DONE.
- pass  out  1  valid when done is high.
- fail_count  out  $clog2(NUM_REGS+1)  number of mismatches.
- fail_index  out  $clog2(NUM_REGS)  index of the first mismatch; 0 if none.
- fail_actual  out  DATA_W  register value at the first mismatch.
- fail_expected  out  DATA_W  expected value at the first mismatch.

Behaviour:
- Reset (reset==0 at a clock edge) puts the block in IDLE:
  - cpu_reset=1; rf_we=0; busy=0; done=0; pass=0.
  - fail_count, fail_index, fail_actual, fail_expected = 0.
  - The expected image is not cleared.
  - Reset mid-run aborts immediately, with the same values.
- IDLE:
  - cpu_reset=1.
  - exp_we writes {exp_care, exp_data} at exp_addr; writes to index 0 are ignored.
  - start -> INIT on the next edge: idx=1, budget latched, status outputs cleared.
- INIT:
  - One write per cycle: rf_we=1, rf_waddr=idx, rf_wdata=INIT_VALUE; cpu_reset=1.
  - Lasts NUM_REGS-1 cycles, then HOLD.
- HOLD: cpu_reset=1, rf_we=0 for RESET_CYCLES cycles, then RUN.
- RUN:
  - cpu_reset=0 for exactly cycle_budget cycles, then CHECK.
  - Budget 0 skips RUN: HOLD goes directly to CHECK.
- CHECK:
  - rf_raddr=idx, starting at 1, with cpu_reset=1 so core writes are frozen.
  - Mismatch: care bit set and rf_rdata != expected.
  - Each mismatch increments fail_count; the first one latches fail_index, fail_actual and fail_expected.
  - STOP_ON_FAIL=1: a mismatch goes to DONE on the next edge.
  - Otherwise the scan ends after idx NUM_REGS-1, then DONE.
- DONE:
  - done=1; pass=(fail_count==0); cpu_reset=1.
  - Expected-image writes are allowed.
  - start restarts at INIT and clears the status outputs.
- start in busy states is ignored.
- exp_we in busy states is ignored; the image is not modified.
- Total latency from start to done:
  - STOP_ON_FAIL=0, or no mismatch: 1 + (NUM_REGS-1) + RESET_CYCLES + cycle_budget + (NUM_REGS-1) cycles.
  - STOP_ON_FAIL=1 with a mismatch: the CHECK term shortens to the index of the first mismatch.
- Counters saturate; there is no wrap, since idx never exceeds NUM_REGS-1.

Decomposition:
- Shared package proc_sim_pkg:
  - state enum {IDLE, INIT, HOLD, RUN, CHECK, DONE};
  - DEFAULT_INIT_VALUE constant;
  - address-width helper function.
- One sub-module, exp_image_ram:
  - NUM_REGS x (DATA_W+1);
  - one synchronous write port, one combinational read port.

Test Plan:
- FunctionCall-style image: registers match, cycle_budget=5, defaults -> done after 1+31+2+5+31=70 cycles; pass=1; fail_count=0; exactly 31 rf_we pulses, each with data 32'hcafebabe.
- Expected r5=32'h00000008 and core leaves r5=32'h00000007, STOP_ON_FAIL=1 -> done with fail_index=5, fail_actual=32'h7, fail_expected=32'h8, fail_count=1; the scan never reads r6.
- STOP_ON_FAIL=0, mismatches at r3 and r9 -> fail_count=2; fail_index=3; scan covers all 31 registers.
- r9 marked don't-care and holding garbage, other registers match -> pass=1.
- cycle_budget=0 -> cpu_reset never deasserts; HOLD goes directly to CHECK; untouched registers read 32'hcafebabe and match an all-marker image.
- reset low during RUN, then start after release -> cpu_reset=1 and outputs return to reset values; the new run completes normally; start and exp_we pulses during busy states have no effect.
